// File: rtl/inst_mem_responder_pkg.sv
// Shared widths, constants and FSM encoding for the instruction-side memory responder.
package inst_mem_responder_pkg;

   localparam int INST_ADDR_BUS_W = 32;
   localparam int INST_BUS_W      = 32;
   localparam int INST_BYTES      = 4;

   localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;
   localparam logic                  TRUE      = 1'b1;
   localparam logic                  FALSE     = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch-side request/response and byte-wide RAM port of the instruction responder.
interface inst_mem_responder_if
   import inst_mem_responder_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS_W
) ();

   logic                  inst_enable;
   logic [ADDR_W-1:0]     pc_i;
   logic                  jmp;
   logic                  arb_busy;
   logic [7:0]            mem_din;
   logic [ADDR_W-1:0]     mem_a;
   logic                  mem_wr;
   logic [INST_BUS_W-1:0] inst_o;
   logic                  inst_ok;

   // master: the IF stage plus RAM side; slave: the responder itself
   modport master (
      output inst_enable, pc_i, jmp, arb_busy, mem_din,
      input  mem_a, mem_wr, inst_o, inst_ok
   );

   modport slave (
      input  inst_enable, pc_i, jmp, arb_busy, mem_din,
      output mem_a, mem_wr, inst_o, inst_ok
   );

endinterface

// File: rtl/inst_mem_responder.sv
// Fetches one 32-bit little-endian instruction as four sequential byte reads from a
// synchronous read-only RAM and returns it with a single-cycle inst_ok pulse.
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int ADDR_W     = INST_ADDR_BUS_W,
   parameter int INST_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   inst_mem_responder_if.slave   bus
);

   // cnt_reg counts READ edges: 0..2 advance the address, 1..4 capture lanes 0..3
   localparam logic [2:0] LAST_STEP = 3'(INST_BYTES);

   state_t                state_reg, state_next;
   logic [2:0]            cnt_reg, cnt_next;
   logic [ADDR_W-1:0]     base_reg, base_next;
   logic [ADDR_W-1:0]     mem_a_reg, mem_a_next;
   logic [INST_BUS_W-1:0] shift_reg, shift_next;
   logic [INST_BUS_W-1:0] inst_reg, inst_next;
   logic                  ok_reg, ok_next;

   logic                  capture;
   logic [1:0]            lane_idx;
   logic [3:0]            lane_hit;
   logic [INST_BUS_W-1:0] assembled;

   assign capture  = (state_reg == ST_READ) && (cnt_reg != 3'd0);
   assign lane_idx = cnt_reg[1:0] - 2'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_hit[gi]           = capture && (lane_idx == 2'(gi));
         assign assembled[8*gi +: 8]   = lane_hit[gi] ? bus.mem_din : shift_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 3'd0;
         base_reg  <= '0;
         mem_a_reg <= '0;
         shift_reg <= ZERO_WORD;
         inst_reg  <= ZERO_WORD;
         ok_reg    <= FALSE;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         base_reg  <= base_next;
         mem_a_reg <= mem_a_next;
         shift_reg <= shift_next;
         inst_reg  <= inst_next;
         ok_reg    <= ok_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      base_next  = base_reg;
      mem_a_next = mem_a_reg;
      shift_next = shift_reg;
      inst_next  = inst_reg;
      ok_next    = FALSE;

      case (state_reg)
         ST_IDLE: begin
            // jmp takes priority over a simultaneous request
            if (bus.inst_enable && !bus.jmp && !bus.arb_busy) begin
               base_next  = bus.pc_i;
               mem_a_next = bus.pc_i;
               cnt_next   = 3'd0;
               shift_next = ZERO_WORD;
               state_next = ST_READ;
            end
         end

         ST_READ: begin
            if (bus.jmp || (bus.pc_i != base_reg)) begin
               state_next = ST_IDLE;
               mem_a_next = '0;
               cnt_next   = 3'd0;
               shift_next = ZERO_WORD;
            end else begin
               if (cnt_reg < 3'd3)
                  mem_a_next = base_reg + ADDR_W'(cnt_reg) + ADDR_W'(1);
               shift_next = assembled;
               if (cnt_reg == LAST_STEP) begin
                  inst_next  = assembled;
                  ok_next    = TRUE;
                  cnt_next   = 3'd0;
                  state_next = ST_DONE;
               end else begin
                  cnt_next = cnt_reg + 3'd1;
               end
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.mem_a   = mem_a_reg;
   assign bus.mem_wr  = FALSE;
   assign bus.inst_o  = inst_reg;
   assign bus.inst_ok = ok_reg;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: basic, blocked, aborted, wrapped and back-to-back fetches.
module tb_inst_mem_responder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   ok_count;
   int   cyc;

   inst_mem_responder_if bus ();

   inst_mem_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM contents: a few hand-placed bytes, everything else a simple address hash
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h100: ram_byte = 8'h13;
         32'h101: ram_byte = 8'h05;
         32'h102: ram_byte = 8'h10;
         32'h103: ram_byte = 8'h00;
         default: ram_byte = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   always @(posedge clk) bus.mem_din <= ram_byte(bus.mem_a);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.inst_ok) ok_count++;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_word,
                        input bit busy_in_read, input string tag);
      int          lat;
      int          base_ok;
      logic [31:0] a;
      base_ok         = ok_count;
      bus.inst_enable = 1'b1;
      bus.pc_i        = pc;
      tick();
      check_eq({tag, ".mem_a0"}, bus.mem_a, pc);
      check_eq({tag, ".mem_wr"}, bus.mem_wr, 1'b0);
      if (busy_in_read) bus.arb_busy = 1'b1;
      for (int k = 1; k < 4; k++) begin
         tick();
         a = pc + 32'(k);
         check_eq($sformatf("%s.mem_a%0d", tag, k), bus.mem_a, a);
         check_eq($sformatf("%s.early_ok%0d", tag, k), bus.inst_ok, 1'b0);
      end
      lat = 3;
      while (!bus.inst_ok && lat < 12) begin
         tick();
         lat++;
      end
      check_eq({tag, ".latency"}, lat, 5);
      check_eq({tag, ".inst_o"}, bus.inst_o, exp_word);
      bus.inst_enable = 1'b0;
      bus.arb_busy    = 1'b0;
      tick();
      check_eq({tag, ".ok_drop"}, bus.inst_ok, 1'b0);
      check_eq({tag, ".ok_count"}, ok_count, base_ok + 1);
   endtask

   initial begin
      int t1;
      int t2;
      int base_ok;
      int guard;
      n_checks        = 0;
      n_fail          = 0;
      ok_count        = 0;
      cyc             = 0;
      rst             = 1'b0;
      bus.inst_enable = 1'b0;
      bus.pc_i        = '0;
      bus.jmp         = 1'b0;
      bus.arb_busy    = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_eq("rst.mem_a", bus.mem_a, 32'h0);
      check_eq("rst.inst_o", bus.inst_o, 32'h0);
      check_eq("rst.inst_ok", bus.inst_ok, 1'b0);
      check_eq("rst.mem_wr", bus.mem_wr, 1'b0);

      // blocked start, then basic fetch with arb_busy raised mid-READ
      bus.arb_busy    = 1'b1;
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("blocked.mem_a%0d", i), bus.mem_a, 32'h0);
         check_eq($sformatf("blocked.ok%0d", i), bus.inst_ok, 1'b0);
      end
      bus.arb_busy = 1'b0;
      fetch(32'h100, 32'h00100513, 1'b1, "basic");

      // jmp at the second READ edge
      base_ok         = ok_count;
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h100;
      tick();
      tick();
      bus.jmp = 1'b1;
      tick();
      check_eq("jmp.mem_a", bus.mem_a, 32'h0);
      bus.jmp = 1'b0;
      fetch(32'h200, 32'hA4A5A6A7, 1'b0, "after_jmp");
      check_eq("jmp.no_extra_ok", ok_count, base_ok + 1);

      // jmp and request in the same IDLE cycle: no start
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h104;
      bus.jmp         = 1'b1;
      tick();
      tick();
      check_eq("jmp_idle.mem_a", bus.mem_a, 32'h103 + 32'h100);
      bus.jmp         = 1'b0;
      bus.inst_enable = 1'b0;
      tick();

      // pc change mid-READ aborts and restarts at the new pc
      base_ok         = ok_count;
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h100;
      tick();
      tick();
      bus.pc_i = 32'h104;
      tick();
      check_eq("pcchg.mem_a", bus.mem_a, 32'h0);
      check_eq("pcchg.ok", bus.inst_ok, 1'b0);
      fetch(32'h104, 32'hA3A2A1A0, 1'b0, "pcchg");
      check_eq("pcchg.one_ok", ok_count, base_ok + 1);

      fetch(32'hFFFF_FFFC, 32'h5A5B5859, 1'b0, "wrap");

      // back-to-back fetches at 0x0 and 0x4 with inst_enable held
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h0;
      guard           = 0;
      tick();
      while (!bus.inst_ok && guard < 20) begin
         tick();
         guard++;
      end
      check_eq("b2b.first_seen", bus.inst_ok, 1'b1);
      check_eq("b2b.word0", bus.inst_o, 32'hA6A7A4A5);
      t1       = cyc;
      bus.pc_i = 32'h4;
      tick();
      check_eq("b2b.done_drop", bus.inst_ok, 1'b0);
      tick();
      check_eq("b2b.start_a", bus.mem_a, 32'h4);
      guard = 0;
      while (!bus.inst_ok && guard < 20) begin
         tick();
         guard++;
      end
      t2 = cyc;
      check_eq("b2b.second_seen", bus.inst_ok, 1'b1);
      check_eq("b2b.word1", bus.inst_o, 32'hA2A3A0A1);
      check_eq("b2b.spacing", t2 - t1, 7);
      bus.inst_enable = 1'b0;
      tick();

      // asynchronous reset in the middle of a READ
      bus.inst_enable = 1'b1;
      bus.pc_i        = 32'h200;
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_eq("arst.mem_a", bus.mem_a, 32'h0);
      check_eq("arst.inst_o", bus.inst_o, 32'h0);
      check_eq("arst.inst_ok", bus.inst_ok, 1'b0);
      bus.inst_enable = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      check_eq("arst.idle_a", bus.mem_a, 32'h0);
      check_eq("arst.idle_ok", bus.inst_ok, 1'b0);
      fetch(32'h200, 32'hA4A5A6A7, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
